prefetch_queue: RTL and testbench
=================================

# prefetch_queue

Instruction prefetch queue for the 8088-style core. It sits between the 8-bit external memory bus and the instruction decoder. It fetches code bytes from physical address CS·16 + fetch pointer and buffers up to DEPTH bytes. It presents the oldest four bytes as a little-endian 32-bit Instruction word, and retires bytes as the decoder consumes them.

## Interface
- DEPTH, 4: queue capacity in bytes; legal range 4..8.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- CS  in  16  code segment; sampled when a fetch address is formed.
- flush  in  1  discard queue and restart fetching at new_ip.
- new_ip  in  16  jump target, used when flush=1.
- consume  in  1  decoder retires consume_len bytes this cycle.
- consume_len  in  3  bytes retired; legal 1..4.
- Bus  in  8  read data from memory, valid with mem_ack.
- mem_ack  in  1  memory completes the current read.
- mem_req  out  1  read request, registered.
- Direction  out  20  physical fetch address, registered.
- Instruction  out  32  queue bytes head..head+3; head byte in [7:0].
- count  out  4  bytes currently held.
- IP  out  16  offset of the head byte (the decoder's instruction pointer).
- consume_err  out  1  illegal consume pulse (only with PFQ_CONSUME_ERR_EN).

## Operation
- **Reset values.** mem_req=0, Direction=20'h00000, count=0, IP=16'h0000, fetch pointer=16'h0000, Instruction=0, consume_err=0. The FSM is in IDLE.
- **FSM states.** IDLE and REQ.
  - IDLE→REQ when there is no flush and count_next<DEPTH. On this transition Direction ← ({CS,4'h0} + fetch_ptr) mod 2^20.
  - REQ holds mem_req and Direction stable until mem_ack=1.
  - On ack: Bus is written at the tail, fetch_ptr increments, and count increments.
  - After the ack, if count_next<DEPTH the FSM stays in REQ and Direction is recomputed with the incremented fetch_ptr. Otherwise it goes to IDLE.
- Only one request is outstanding at a time. mem_ack while mem_req=0 is ignored.
- **Consume.** When consume=1 and 1≤consume_len≤count (count before this cycle's ack): head advances by consume_len, IP += consume_len, count -= consume_len.
- **Illegal consume.** consume_len=0 or consume_len>count is ignored entirely; the queue is unchanged.
- **Simultaneous ack and consume.** Both are applied: count_next = count + 1 − consume_len.
- **Flush priority.** flush overrides everything in the same cycle.
  - count ← 0; head and tail pointers ← 0; IP ← new_ip; fetch_ptr ← new_ip; FSM → IDLE.
  - A same-cycle mem_ack byte is discarded.
  - A same-cycle consume is ignored and does not raise consume_err.
- **Wrap rules.**
  - fetch_ptr and IP wrap modulo 2^16: 16'hFFFF+1=16'h0000. This is segment wrap; the segment is not incremented.
  - Direction wraps modulo 2^20.
  - Queue pointers wrap modulo DEPTH.
- **Instruction.** Byte i (i=0..3) is queue entry head+i when i<count, otherwise 8'h00. It is combinational from the queue registers.
- **Async reset.** Asserting reset mid-request drops mem_req immediately. A late mem_ack after reset release is ignored.

## Timing
- The first mem_req rises one clk edge after reset is released.
- A byte acked at edge k is visible in count and Instruction after edge k.
- Back-to-back acks give 1 byte/cycle throughput while space remains.
- Flush sampled at edge n:
  - mem_req=0 after edge n.
  - mem_req=1 with Direction={CS,4'h0}+new_ip after edge n+1.
- The queue becomes full at edge k: mem_req=0 after edge k. It re-requests one edge after the first legal consume.
- consume_err is a single-cycle registered pulse, high after the edge sampling the illegal consume.

## Configuration
- **PFQ_CONSUME_ERR_EN defined:**
  - the consume_err port exists;
  - it pulses for one cycle on each illegal consume (len=0 or len>count) that is not masked by flush.
- **PFQ_CONSUME_ERR_EN undefined:**
  - the port and its logic are absent;
  - an illegal consume is still silently ignored, as above.

## Test plan
- **Reset then fill.** Release reset with CS=16'h1000; memory acks every cycle with Bus=8'hA0+n. Required: Direction sequence 20'h10000..20'h10003; count reaches 4; Instruction=32'hA3A2A1A0; mem_req falls.
- **Consume/refill overlap.** Start with a full queue, IP=0. consume_len=2 in the same cycle as no ack → count=2, IP=2, Instruction=32'h0000A3A2. The next ack (Bus=8'hB4) gives count=3.
- **Simultaneous ack and consume.** With count=3, ack Bus=8'hC5 and consume_len=1 in the same cycle → count=3, IP +1.
- **Flush mid-request.** Hold mem_req=1 without ack, then flush with new_ip=16'hFFFE and assert mem_ack in the same cycle. Required: ack byte dropped; count=0; IP=16'hFFFE; next Direction={CS,4'h0}+16'hFFFE. After two acks, Direction shows offset 16'h0000 (wrap).
- **Illegal consume.** With count=1, consume_len=3 → queue unchanged; consume_err=1 for one cycle (macro defined). consume_len=0 → same.
- **Async reset mid-request.** Assert reset while mem_req=1 → mem_req=0 and count=0 immediately, without waiting for a clk edge. An ack arriving after reset release, before the first new request, is ignored.

Source files
------------

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches code bytes from CS*16+fetch_ptr over an 8-bit bus and
// presents the oldest four as a little-endian word. Optional consume_err port: PFQ_CONSUME_ERR_EN.
module prefetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] CS,
  input  logic        flush,
  input  logic [15:0] new_ip,
  input  logic        consume,
  input  logic [2:0]  consume_len,
  input  logic [7:0]  Bus,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [19:0] Direction,
  output logic [31:0] Instruction,
  output logic [3:0]  count,
  output logic [15:0] IP
`ifdef PFQ_CONSUME_ERR_EN
  ,
  output logic        consume_err
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_e;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [19:0]     dir_q, dir_d;
  logic [15:0]     fptr_q, fptr_d;
  logic [15:0]     ip_q, ip_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [3:0]      count_q, count_d;
  logic [7:0]      mem_q [DEPTH];

  logic            ack_v;
  logic            cons_ok;
  logic            wr_en;
  logic [3:0]      len_eff;

  // Queue pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

  // An ack only counts against an outstanding request; stray acks are dropped.
  assign ack_v   = mem_ack && mem_req_q;
  assign cons_ok = consume && (consume_len != 3'd0) && ({1'b0, consume_len} <= count_q);
  assign len_eff = cons_ok ? {1'b0, consume_len} : 4'd0;

`ifdef PFQ_CONSUME_ERR_EN
  logic err_q, err_d;
  assign err_d       = consume && !cons_ok && !flush;
  assign consume_err = err_q;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    mem_req_d = mem_req_q;
    dir_d     = dir_q;
    fptr_d    = fptr_q;
    ip_d      = ip_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wr_en     = 1'b0;

    if (flush) begin
      state_d   = S_IDLE;
      mem_req_d = 1'b0;
      fptr_d    = new_ip;
      ip_d      = new_ip;
      head_d    = '0;
      tail_d    = '0;
      count_d   = 4'd0;
    end else begin
      if (cons_ok) begin
        head_d = ptr_add(head_q, int'(consume_len));
        ip_d   = ip_q + {13'h0000, consume_len};
      end
      if (ack_v) begin
        wr_en  = 1'b1;
        tail_d = ptr_add(tail_q, 1);
        fptr_d = fptr_q + 16'h0001;
      end
      count_d = count_q + {3'b000, ack_v} - len_eff;

      unique case (state_q)
        S_IDLE: begin
          if (count_d < DEPTH_C) begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
            dir_d     = phys_addr(CS, fptr_q);
          end
        end
        S_REQ: begin
          if (ack_v) begin
            if (count_d < DEPTH_C) begin
              dir_d = phys_addr(CS, fptr_d);
            end else begin
              state_d   = S_IDLE;
              mem_req_d = 1'b0;
            end
          end
        end
        default: begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mem_req_q <= 1'b0;
      dir_q     <= 20'h00000;
      fptr_q    <= 16'h0000;
      ip_q      <= 16'h0000;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= 4'd0;
`ifdef PFQ_CONSUME_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      dir_q     <= dir_d;
      fptr_q    <= fptr_d;
      ip_q      <= ip_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
`ifdef PFQ_CONSUME_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  // NOTE: the byte storage is not reset; entries beyond count are masked to zero on the output.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tail_q] <= Bus;
    end
  end

  always_comb begin
    Instruction = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (4'(i) < count_q) begin
        Instruction[8*i +: 8] = mem_q[ptr_add(head_q, i)];
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign Direction = dir_q;
  assign count     = count_q;
  assign IP        = ip_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue (DEPTH=4): vector table plus async-reset and segment-wrap sequences.
module tb_prefetch_queue;

  logic        clk;
  logic        reset;
  logic [15:0] CS;
  logic        flush;
  logic [15:0] new_ip;
  logic        consume;
  logic [2:0]  consume_len;
  logic [7:0]  Bus;
  logic        mem_ack;
  logic        mem_req;
  logic [19:0] Direction;
  logic [31:0] Instruction;
  logic [3:0]  count;
  logic [15:0] IP;
`ifdef PFQ_CONSUME_ERR_EN
  logic        consume_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  prefetch_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .CS          (CS),
    .flush       (flush),
    .new_ip      (new_ip),
    .consume     (consume),
    .consume_len (consume_len),
    .Bus         (Bus),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .Direction   (Direction),
    .Instruction (Instruction),
    .count       (count),
    .IP          (IP)
`ifdef PFQ_CONSUME_ERR_EN
    ,
    .consume_err (consume_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        flush;
    logic [15:0] new_ip;
    logic        consume;
    logic [2:0]  len;
    logic        ack;
    logic [7:0]  bus;
    logic        e_req;
    logic [19:0] e_dir;
    logic [3:0]  e_cnt;
    logic [15:0] e_ip;
    logic [31:0] e_instr;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, input logic [15:0] nip, input logic cons,
                              input logic [2:0] len, input logic ack, input logic [7:0] bus,
                              input logic e_req, input logic [19:0] e_dir, input logic [3:0] e_cnt,
                              input logic [15:0] e_ip, input logic [31:0] e_instr, input logic e_err);
    vec_t v;
    v.flush = fl; v.new_ip = nip; v.consume = cons; v.len = len; v.ack = ack; v.bus = bus;
    v.e_req = e_req; v.e_dir = e_dir; v.e_cnt = e_cnt; v.e_ip = e_ip;
    v.e_instr = e_instr; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; new_ip = 16'h0000; consume = 1'b0; consume_len = 3'd0;
    mem_ack = 1'b0; Bus = 8'h00;
  endtask

  initial begin
    reset = 1'b0;
    CS    = 16'h1000;
    idle_inputs();

    //          flush new_ip    cons len  ack bus     req dir        cnt  ip        instr          err
    vecs.push_back(mk(0, 16'h0000, 0, 3'd0, 0, 8'h00, 1, 20'h10000, 4'd0, 16'h0000, 32'h00000000, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 3'd0, 1, 8'hA0, 1, 20'h10001, 4'd1, 16'h0000, 32'h000000A0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 3'd0, 1, 8'hA1, 1, 20'h10002, 4'd2, 16'h0000, 32'h0000A1A0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 3'd0, 1, 8'hA2, 1, 20'h10003, 4'd3, 16'h0000, 32'h00A2A1A0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 3'd0, 1, 8'hA3, 0, 20'h10003, 4'd4, 16'h0000, 32'hA3A2A1A0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 3'd0, 0, 8'h00, 0, 20'h10003, 4'd4, 16'h0000, 32'hA3A2A1A0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 3'd0, 1, 8'hA9, 0, 20'h10003, 4'd4, 16'h0000, 32'hA3A2A1A0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd2, 0, 8'h00, 1, 20'h10004, 4'd2, 16'h0002, 32'h0000A3A2, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 3'd0, 1, 8'hB4, 1, 20'h10005, 4'd3, 16'h0002, 32'h00B4A3A2, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd1, 1, 8'hC5, 1, 20'h10006, 4'd3, 16'h0003, 32'h00C5B4A3, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd0, 0, 8'h00, 1, 20'h10006, 4'd3, 16'h0003, 32'h00C5B4A3, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd4, 0, 8'h00, 1, 20'h10006, 4'd3, 16'h0003, 32'h00C5B4A3, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 3'd0, 0, 8'h00, 1, 20'h10006, 4'd3, 16'h0003, 32'h00C5B4A3, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd3, 0, 8'h00, 1, 20'h10006, 4'd0, 16'h0006, 32'h00000000, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd1, 1, 8'hD6, 1, 20'h10007, 4'd1, 16'h0006, 32'h000000D6, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd3, 0, 8'h00, 1, 20'h10007, 4'd1, 16'h0006, 32'h000000D6, 1));
    vecs.push_back(mk(1, 16'hFFFE, 1, 3'd1, 1, 8'hEE, 0, 20'h10007, 4'd0, 16'hFFFE, 32'h00000000, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 3'd0, 0, 8'h00, 1, 20'h1FFFE, 4'd0, 16'hFFFE, 32'h00000000, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 3'd0, 1, 8'h11, 1, 20'h1FFFF, 4'd1, 16'hFFFE, 32'h00000011, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 3'd0, 1, 8'h22, 1, 20'h10000, 4'd2, 16'hFFFE, 32'h00002211, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 3'd2, 0, 8'h00, 1, 20'h10000, 4'd0, 16'h0000, 32'h00000000, 0));

    // Reset state, held across a couple of clock edges.
    repeat (2) @(posedge clk);
    #1;
    check("rst.mem_req", 32'(mem_req), 32'h0);
    check("rst.Direction", 32'(Direction), 32'h0);
    check("rst.count", 32'(count), 32'h0);
    check("rst.IP", 32'(IP), 32'h0);
    check("rst.Instruction", Instruction, 32'h0);
`ifdef PFQ_CONSUME_ERR_EN
    check("rst.consume_err", 32'(consume_err), 32'h0);
`endif

    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      flush = vecs[i].flush; new_ip = vecs[i].new_ip; consume = vecs[i].consume;
      consume_len = vecs[i].len; mem_ack = vecs[i].ack; Bus = vecs[i].bus;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      check($sformatf("v%0d.Direction", i), 32'(Direction), 32'(vecs[i].e_dir));
      check($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d.IP", i), 32'(IP), 32'(vecs[i].e_ip));
      check($sformatf("v%0d.Instruction", i), Instruction, vecs[i].e_instr);
`ifdef PFQ_CONSUME_ERR_EN
      check($sformatf("v%0d.consume_err", i), 32'(consume_err), 32'(vecs[i].e_err));
`endif
    end

    // Async reset while a request is outstanding: outputs clear before any clock edge.
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1;
    check("arst.mem_req", 32'(mem_req), 32'h0);
    check("arst.count", 32'(count), 32'h0);
    check("arst.Direction", 32'(Direction), 32'h0);
    check("arst.IP", 32'(IP), 32'h0);

    // A late ack right after release must not be captured.
    @(negedge clk);
    reset   = 1'b1;
    mem_ack = 1'b1;
    Bus     = 8'h77;
    @(posedge clk);
    #1;
    check("late_ack.mem_req", 32'(mem_req), 32'h1);
    check("late_ack.Direction", 32'(Direction), 32'h10000);
    check("late_ack.count", 32'(count), 32'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    check("late_ack.count2", 32'(count), 32'h0);
    check("late_ack.Instruction", Instruction, 32'h0);

    // Flush with a high segment: physical address wraps modulo 2^20.
    @(negedge clk);
    CS     = 16'hFFFF;
    flush  = 1'b1;
    new_ip = 16'h0020;
    @(posedge clk);
    #1;
    check("cswrap.mem_req0", 32'(mem_req), 32'h0);
    check("cswrap.IP", 32'(IP), 32'h0020);
    @(negedge clk);
    flush = 1'b0;
    @(posedge clk);
    #1;
    check("cswrap.mem_req1", 32'(mem_req), 32'h1);
    check("cswrap.Direction", 32'(Direction), 32'h00010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
